// File: rtl/pipe_queue.sv
// DEPTH-entry stage-decoupling FIFO with show-ahead head; 1-cycle push-to-head (0 with BYPASS on empty).
// o_stall is registered-only (full) unless FULL_PASS lets a same-cycle pop free the slot; flush kills all.
module pipe_queue #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 4,
    parameter int BYPASS    = 0,
    parameter int FULL_PASS = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_stall,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_stall,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   L_DEPTH = CW'(DEPTH);
    localparam logic            L_BYP   = (BYPASS != 0);
    localparam logic            L_FPASS = (FULL_PASS != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_rd;

    always_comb begin
        w_empty  = (r_count == '0);
        w_full   = (r_count == L_DEPTH);
        w_bypass = L_BYP && w_empty;
        o_valid  = !i_flush && (w_empty ? (w_bypass && i_valid) : 1'b1);
        o_data   = w_bypass ? i_data : r_mem[r_rd_ptr];
        o_stall  = !i_flush && w_full && (L_FPASS ? i_stall : 1'b1);
        w_push   = i_valid && !o_stall && !i_flush;
        w_pop    = o_valid && !i_stall;
        // A bypassed entry consumed in the same cycle never touches storage.
        w_wr     = w_push && !(w_bypass && w_pop);
        w_rd     = w_pop && !w_empty;
    end

    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr, so the write lands in the slot being freed.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) r_mem[r_wr_ptr] <= i_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (r_count <= L_DEPTH);
            assert (!(w_wr && w_full && !w_rd));
        end
        assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
    end
`endif

endmodule

// File: tb/tb_pipe_queue.sv
// Bench for pipe_queue: a plain instance and a BYPASS+FULL_PASS instance, checked against a queue scoreboard.
module tb_pipe_queue;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld [2];
    logic [63:0] dat [2];
    logic        stl [2];
    logic        fl  [2];

    logic        o_stall_a [2];
    logic        o_valid_a [2];
    logic [63:0] o_data_a  [2];
    logic [2:0]  o_count_a [2];
    logic        o_empty_a [2];
    logic        o_full_a  [2];

    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    bit          pushed [2];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_queue #(.DATA_W(64), .DEPTH(D), .BYPASS(0), .FULL_PASS(0)) u_base (
        .i_clk(clk), .i_rst(rst), .i_flush(fl[0]), .i_valid(vld[0]), .i_data(dat[0]),
        .o_stall(o_stall_a[0]), .o_valid(o_valid_a[0]), .o_data(o_data_a[0]),
        .i_stall(stl[0]), .o_count(o_count_a[0]), .o_empty(o_empty_a[0]), .o_full(o_full_a[0])
    );

    pipe_queue #(.DATA_W(64), .DEPTH(D), .BYPASS(1), .FULL_PASS(1)) u_pass (
        .i_clk(clk), .i_rst(rst), .i_flush(fl[1]), .i_valid(vld[1]), .i_data(dat[1]),
        .o_stall(o_stall_a[1]), .o_valid(o_valid_a[1]), .o_data(o_data_a[1]),
        .i_stall(stl[1]), .o_count(o_count_a[1]), .o_empty(o_empty_a[1]), .o_full(o_full_a[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for instance k over the coming clock edge.
    task automatic model(input int k);
        logic [63:0] q [$];
        logic [63:0] exp_d;
        int          n;
        bit          bp, fp, ev, es, push, pop;
        if (k == 0) q = q0; else q = q1;
        bp = (k == 1);
        fp = (k == 1);
        n  = q.size();
        ev = !fl[k] && (n > 0 || (bp && vld[k]));
        es = !fl[k] && (n == D) && (fp ? stl[k] : 1'b1);
        push = !rst && vld[k] && !es && !fl[k];
        pop  = !rst && ev && !stl[k];
        pushed[k] = push;
        if (!rst) begin
            chk($sformatf("u%0d.count", k), 64'(o_count_a[k]), 64'(n));
            chk($sformatf("u%0d.empty", k), 64'(o_empty_a[k]), 64'(n == 0));
            chk($sformatf("u%0d.full", k),  64'(o_full_a[k]),  64'(n == D));
            chk($sformatf("u%0d.valid", k), 64'(o_valid_a[k]), 64'(ev));
            chk($sformatf("u%0d.stall", k), 64'(o_stall_a[k]), 64'(es));
        end
        if (rst || fl[k]) begin
            q.delete();
        end else begin
            if (push) q.push_back(dat[k]);
            if (pop) begin
                exp_d = q.pop_front();
                chk($sformatf("u%0d.pop_data", k), o_data_a[k], exp_d);
            end else if (ev) begin
                exp_d = (n > 0) ? q[0] : dat[k];
                chk($sformatf("u%0d.head_data", k), o_data_a[k], exp_d);
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    task automatic step();
        #2;
        model(0);
        model(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit v, input logic [63:0] d, input bit s, input bit f);
        vld[k]   = v;
        dat[k]   = d;
        stl[k]   = s;
        fl[k]    = f;
        vld[1-k] = 1'b0;
        stl[1-k] = 1'b1;
        fl[1-k]  = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; dat[k] = '0; stl[k] = 1'b1; fl[k] = 1'b0;
        end
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();

        // Fill to full with the downstream stalled; the fifth entry is held upstream.
        for (int i = 1; i <= 5; i++) drive(0, 1'b1, 64'(i), 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            drive(0, 1'b1, 64'd5, 1'b0, 1'b0);
            if (pushed[0]) break;
        end
        repeat (6) drive(0, 1'b0, 64'd0, 1'b0, 1'b0);

        // Simultaneous push and pop at count 2.
        drive(0, 1'b1, 64'h11, 1'b1, 1'b0);
        drive(0, 1'b1, 64'h12, 1'b1, 1'b0);
        drive(0, 1'b1, 64'hA,  1'b0, 1'b0);
        repeat (4) drive(0, 1'b0, 64'd0, 1'b0, 1'b0);

        // Flush at count 3 with a concurrent push of 0xB.
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 64'h21 + 64'(i), 1'b1, 1'b0);
        drive(0, 1'b1, 64'hB, 1'b1, 1'b1);
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);

        // Flush while full, downstream ready and upstream pushing.
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 64'h31 + 64'(i), 1'b1, 1'b0);
        drive(0, 1'b1, 64'h3F, 1'b0, 1'b1);
        drive(0, 1'b0, 64'd0, 1'b0, 1'b0);

        // Bypass on empty: pass-through, then captured when stalled.
        drive(1, 1'b1, 64'hC, 1'b0, 1'b0);
        drive(1, 1'b1, 64'hC, 1'b1, 1'b0);
        drive(1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Full-pass: fill, refused push while stalled, accepted push with a pop.
        for (int i = 0; i < 3; i++) drive(1, 1'b1, 64'h41 + 64'(i), 1'b1, 1'b0);
        drive(1, 1'b1, 64'h44, 1'b1, 1'b0);
        drive(1, 1'b1, 64'h20, 1'b0, 1'b0);
        drive(1, 1'b1, 64'h21, 1'b0, 1'b0);

        // Reset mid-stream.
        rst = 1'b1;
        drive(1, 1'b1, 64'h22, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1, 1'b0, 64'd0, 1'b1, 1'b0);

        // Flush kills the bypass path.
        drive(1, 1'b1, 64'hD, 1'b0, 1'b1);
        drive(1, 1'b0, 64'd0, 1'b0, 1'b0);

        // Random traffic on both instances.
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                vld[k] = 1'($urandom_range(0, 1));
                dat[k] = {$urandom, $urandom};
                stl[k] = ($urandom_range(0, 2) == 0);
                fl[k]  = ($urandom_range(0, 24) == 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; stl[k] = 1'b0; fl[k] = 1'b0;
        end
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
